// File: rtl/pacman_pkg.sv
// Shared Pac-Man types and maze geometry, used by the motion controller and the wall renderer.
package pacman_pkg;

  typedef enum logic [1:0] {DIR_U = 2'd0, DIR_D = 2'd1, DIR_L = 2'd2, DIR_R = 2'd3} dir_t;

  localparam logic [9:0] OFFSETH = 10'd274;
  localparam logic [9:0] OFFSETV = 10'd58;
  localparam logic [9:0] MAZE_W  = 10'd380;
  localparam logic [9:0] MAZE_H  = 10'd432;
  localparam logic [9:0] HALF    = 10'd10;

  localparam logic [11:0] COL_WALL = 12'h00F;
  localparam logic [11:0] COL_PAC  = 12'hFF0;
  localparam logic [11:0] COL_BG   = 12'h000;

  // Signed offset along one axis: -step toward neg, +step toward pos, else 0.
  function automatic logic signed [11:0] axis_delta(input dir_t d, input dir_t neg,
                                                    input dir_t pos, input logic [9:0] step);
    if (d == neg) return -$signed({2'b00, step});
    if (d == pos) return $signed({2'b00, step});
    return 12'sd0;
  endfunction

  function automatic logic [9:0] clamp_step(input logic [9:0] p, input logic signed [11:0] d,
                                            input logic [9:0] lo, input logic [9:0] hi);
    logic signed [11:0] s;
    s = $signed({2'b00, p}) + d;
    if (s < $signed({2'b00, lo})) return lo;
    if (s > $signed({2'b00, hi})) return hi;
    return s[9:0];
  endfunction

endpackage

// File: rtl/pacman_motion_ctrl_box_probe.sv
// Collision probe: flags a wall pixel inside Pac-Man's box shifted by (dx, dy), in screen coordinates.
module box_probe #(
  parameter logic [9:0] HALF    = 10'd10,
  parameter logic [9:0] OFFSETH = 10'd274,
  parameter logic [9:0] OFFSETV = 10'd58
) (
  input  logic [9:0]        cx,
  input  logic [9:0]        cy,
  input  logic signed [11:0] dx,
  input  logic signed [11:0] dy,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic              wallFill,
  input  logic              bright,
  output logic              hit
);

  logic signed [11:0] x_lo, x_hi, y_lo, y_hi, h, v;

  // Signed 12-bit arithmetic keeps bounds from wrapping near the maze edges.
  always_comb begin
    x_lo = $signed({2'b00, cx}) + $signed({2'b00, OFFSETH}) - $signed({2'b00, HALF}) + dx;
    x_hi = $signed({2'b00, cx}) + $signed({2'b00, OFFSETH}) + $signed({2'b00, HALF}) + dx;
    y_lo = $signed({2'b00, cy}) + $signed({2'b00, OFFSETV}) - $signed({2'b00, HALF}) + dy;
    y_hi = $signed({2'b00, cy}) + $signed({2'b00, OFFSETV}) + $signed({2'b00, HALF}) + dy;
    h    = $signed({2'b00, hCount});
    v    = $signed({2'b00, vCount});
    hit  = wallFill && bright && (h >= x_lo) && (h <= x_hi) && (v >= y_lo) && (v <= y_hi);
  end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Pac-Man motion controller: probes walls during scan-out, commits at most one step per
// move opportunity at end-of-frame, with a buffered turn request.
module pacman_motion_ctrl #(
  parameter logic [9:0] START_X  = 10'd190,
  parameter logic [9:0] START_Y  = 10'd320,
  parameter logic [9:0] HALF     = pacman_pkg::HALF,
  parameter logic [9:0] STEP     = 10'd1,
  parameter logic [3:0] MOVE_DIV = 4'd1,
  parameter logic [9:0] OFFSETH  = pacman_pkg::OFFSETH,
  parameter logic [9:0] OFFSETV  = pacman_pkg::OFFSETV,
  parameter logic [9:0] EOF_LINE = 10'd515,
  parameter logic [9:0] MAZE_W   = pacman_pkg::MAZE_W,
  parameter logic [9:0] MAZE_H   = pacman_pkg::MAZE_H
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       bright,
  input  logic       wallFill,
  output logic [9:0] pacX,
  output logic [9:0] pacY,
  output logic [1:0] dir,
  output logic       moving
);
  import pacman_pkg::*;

  logic [9:0] pac_x_q, pac_x_d, pac_y_q, pac_y_d;
  dir_t       dir_q, dir_d, req_q, req_d;
  logic       moving_q, moving_d, armed_q, armed_d;
  logic       hit_req_q, hit_req_d, hit_cur_q, hit_cur_d;
  logic       eof_line_q, eof_line_d, eof;
  logic [3:0] div_q, div_d;

  logic signed [11:0] dx_req, dy_req, dx_cur, dy_cur;
  logic               probe_req, probe_cur;

  assign dx_req = axis_delta(req_q, DIR_L, DIR_R, STEP);
  assign dy_req = axis_delta(req_q, DIR_U, DIR_D, STEP);
  assign dx_cur = axis_delta(dir_q, DIR_L, DIR_R, STEP);
  assign dy_cur = axis_delta(dir_q, DIR_U, DIR_D, STEP);

  box_probe #(.HALF(HALF), .OFFSETH(OFFSETH), .OFFSETV(OFFSETV)) u_req_probe (
    .cx(pac_x_q), .cy(pac_y_q), .dx(dx_req), .dy(dy_req), .hCount(hCount), .vCount(vCount),
    .wallFill(wallFill), .bright(bright), .hit(probe_req));

  box_probe #(.HALF(HALF), .OFFSETH(OFFSETH), .OFFSETV(OFFSETV)) u_cur_probe (
    .cx(pac_x_q), .cy(pac_y_q), .dx(dx_cur), .dy(dy_cur), .hCount(hCount), .vCount(vCount),
    .wallFill(wallFill), .bright(bright), .hit(probe_cur));

  always_comb begin
    eof_line_d = (vCount == EOF_LINE);
    eof        = eof_line_d && !eof_line_q;
    pac_x_d    = pac_x_q;
    pac_y_d    = pac_y_q;
    dir_d      = dir_q;
    req_d      = req_q;
    moving_d   = moving_q;
    armed_d    = armed_q;
    div_d      = div_q;
    hit_req_d  = hit_req_q | probe_req;
    hit_cur_d  = hit_cur_q | probe_cur;
    if (eof) begin
      hit_req_d = 1'b0;
      hit_cur_d = 1'b0;
      armed_d   = 1'b1;
      div_d     = (div_q == MOVE_DIV - 4'd1) ? 4'd0 : div_q + 4'd1;
      if      (btnU) req_d = DIR_U;
      else if (btnD) req_d = DIR_D;
      else if (btnL) req_d = DIR_L;
      else if (btnR) req_d = DIR_R;
      // Decision uses the request that was probed over the frame just finished.
      if (armed_q && div_q == MOVE_DIV - 4'd1) begin
        if (!hit_req_q) begin
          dir_d    = req_q;
          pac_x_d  = clamp_step(pac_x_q, dx_req, HALF, MAZE_W - HALF);
          pac_y_d  = clamp_step(pac_y_q, dy_req, HALF, MAZE_H - HALF);
          moving_d = 1'b1;
        end else if (!hit_cur_q) begin
          pac_x_d  = clamp_step(pac_x_q, dx_cur, HALF, MAZE_W - HALF);
          pac_y_d  = clamp_step(pac_y_q, dy_cur, HALF, MAZE_H - HALF);
          moving_d = 1'b1;
        end else begin
          moving_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pac_x_q    <= START_X;
      pac_y_q    <= START_Y;
      dir_q      <= DIR_L;
      req_q      <= DIR_L;
      moving_q   <= 1'b0;
      armed_q    <= 1'b0;
      hit_req_q  <= 1'b0;
      hit_cur_q  <= 1'b0;
      div_q      <= 4'd0;
      eof_line_q <= 1'b0;
    end else begin
      pac_x_q    <= pac_x_d;
      pac_y_q    <= pac_y_d;
      dir_q      <= dir_d;
      req_q      <= req_d;
      moving_q   <= moving_d;
      armed_q    <= armed_d;
      hit_req_q  <= hit_req_d;
      hit_cur_q  <= hit_cur_d;
      div_q      <= div_d;
      eof_line_q <= eof_line_d;
    end
  end

  assign pacX   = pac_x_q;
  assign pacY   = pac_y_q;
  assign dir    = dir_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Directed bench for pacman_motion_ctrl: frame-by-frame vector table plus reset/divider/clamp sequences.
module tb_pacman_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rst3 = 1'b1;
  logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic [9:0] hCount = '0, vCount = '0;
  logic       bright = 1'b0;
  logic       wallFill, wf3;
  logic       col_en = 1'b0, row_en = 1'b0;
  logic [9:0] col = '0, row = '0;
  logic [9:0] pacX, pacY, pacX3, pacY3;
  logic [1:0] dir, dir3;
  logic       moving, moving3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Wall stub: a full column and/or a full row of wall pixels.
  assign wallFill = bright && ((col_en && hCount == col) || (row_en && vCount == row));
  assign wf3 = 1'b0;

  pacman_motion_ctrl dut (
    .clk(clk), .reset(reset), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .hCount(hCount), .vCount(vCount), .bright(bright), .wallFill(wallFill),
    .pacX(pacX), .pacY(pacY), .dir(dir), .moving(moving));

  pacman_motion_ctrl #(.START_X(10'd15), .STEP(10'd3), .MOVE_DIV(4'd3)) dut3 (
    .clk(clk), .reset(rst3), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .hCount(hCount), .vCount(vCount), .bright(bright), .wallFill(wf3),
    .pacX(pacX3), .pacY(pacY3), .dir(dir3), .moving(moving3));

  typedef struct {
    logic [3:0] btn;   // {U,D,L,R}
    logic       cen;
    int         col;
    logic       ren;
    int         row;
    int         x;
    int         y;
    int         d;
    int         mv;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compressed frame: sweep the region around Pac-Man, then one end-of-frame line.
  task automatic frame();
    bright = 1'b1;
    for (int v = 360; v <= 395; v++) begin
      for (int h = 440; h <= 480; h++) begin
        vCount = 10'(v);
        hCount = 10'(h);
        tick();
      end
    end
    bright = 1'b0;
    hCount = '0;
    vCount = 10'd515;
    tick();
    vCount = '0;
    tick();
  endtask

  task automatic chk_main(input string tag, input int x, input int y, input int d, input int mv);
    chk({tag, "_x"}, int'(pacX), x);
    chk({tag, "_y"}, int'(pacY), y);
    chk({tag, "_dir"}, int'(dir), d);
    chk({tag, "_mv"}, int'(moving), mv);
  endtask

  initial begin
    logic [9:0] ex3 [7];
    logic       mv3 [7];

    // btn,     col,     row,     x,   y,   dir, moving
    tv[0] = '{4'b0010, 1'b1, 453, 1'b0, 0,   190, 320, 2, 0};  // left box blocked at its edge
    tv[1] = '{4'b0010, 1'b1, 452, 1'b0, 0,   189, 320, 2, 1};  // wall one px outside box
    tv[2] = '{4'b0010, 1'b0, 0,   1'b0, 0,   188, 320, 2, 1};
    tv[3] = '{4'b1000, 1'b0, 0,   1'b1, 367, 187, 320, 2, 1};  // up requested, old req used
    tv[4] = '{4'b0000, 1'b0, 0,   1'b1, 367, 186, 320, 2, 1};  // up blocked, continue left
    tv[5] = '{4'b0000, 1'b0, 0,   1'b0, 0,   186, 319, 0, 1};  // buffered turn taken
    tv[6] = '{4'b0000, 1'b0, 0,   1'b0, 0,   186, 318, 0, 1};
    tv[7] = '{4'b0100, 1'b0, 0,   1'b0, 0,   186, 317, 0, 1};  // reversal requested
    tv[8] = '{4'b0000, 1'b0, 0,   1'b0, 0,   186, 318, 1, 1};  // reversal taken

    ex3 = '{10'd15, 10'd15, 10'd12, 10'd12, 10'd12, 10'd10, 10'd10};
    mv3 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset mid-line
    hCount = 10'd100;
    vCount = 10'd200;
    #2 reset = 1'b1;
    #1;
    chk_main("reset", 190, 320, 2, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // First eof only arms
    frame();
    chk_main("arm", 190, 320, 2, 0);

    for (int i = 0; i < 9; i++) begin
      {btnU, btnD, btnL, btnR} = tv[i].btn;
      col_en = tv[i].cen;
      col    = 10'(tv[i].col);
      row_en = tv[i].ren;
      row    = 10'(tv[i].row);
      frame();
      chk_main($sformatf("vec%0d", i), tv[i].x, tv[i].y, tv[i].d, tv[i].mv);
    end
    {btnU, btnD, btnL, btnR} = 4'b0000;
    col_en = 1'b0;
    row_en = 1'b0;

    // Reset mid-frame while moving
    hCount = 10'd300;
    vCount = 10'd200;
    bright = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk_main("rst2", 190, 320, 2, 0);
    tick();
    reset = 1'b0;
    bright = 1'b0;
    tick();
    frame();
    chk_main("rst2_arm", 190, 320, 2, 0);
    frame();
    chk_main("rst2_move", 189, 320, 2, 1);

    // MOVE_DIV=3, STEP=3, starting near the left clamp
    btnL = 1'b1;
    tick();
    rst3 = 1'b0;
    tick();
    for (int e = 0; e < 7; e++) begin
      frame();
      chk($sformatf("div3_eof%0d_x", e + 1), int'(pacX3), int'(ex3[e]));
      chk($sformatf("div3_eof%0d_mv", e + 1), int'(moving3), int'(mv3[e]));
    end
    chk("div3_y", int'(pacY3), 320);
    chk("div3_dir", int'(dir3), 2);
    btnL = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
